// File: rtl/motor_cmd_pkg.sv
// Shared framing constants, command codes, payload lengths and FSM states
// for the motor command decoder.
package motor_cmd_pkg;

    localparam logic [7:0] SOM         = 8'h55;
    localparam logic [7:0] CMD_TICS    = 8'h11;
    localparam logic [7:0] CMD_SPEED   = 8'h21;
    localparam logic [7:0] CMD_ACCEL   = 8'h23;
    localparam logic [7:0] CMD_GET_ENC = 8'h24;
    localparam logic [7:0] CMD_RST_ENC = 8'h26;

    typedef enum logic [2:0] {
        IDLE, CMD, PAYLOAD, CHECK, EXEC, TX_SEND, TX_WAIT
    } state_t;

    function automatic logic cmd_known(input logic [7:0] c);
        return c inside {CMD_TICS, CMD_SPEED, CMD_ACCEL, CMD_GET_ENC, CMD_RST_ENC};
    endfunction

    function automatic logic [1:0] payload_len(input logic [7:0] c);
        case (c)
            CMD_TICS, CMD_SPEED:    return 2'd2;
            CMD_ACCEL, CMD_GET_ENC: return 2'd1;
            default:                return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/motor_cmd_tx_serializer.sv
// Sends an encoder read-back frame (SOM, CMD, count bytes MSB first, CHK)
// one byte per tx_dv/tx_done handshake and pulses done after the last byte.
module motor_cmd_tx_serializer
    import motor_cmd_pkg::*;
#(
    parameter int ENC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ENC_W-1:0] word,
    input  logic             tx_done,
    output logic             tx_dv,
    output logic [7:0]       tx_byte,
    output logic             done
);

    localparam int NB  = ENC_W / 8;
    localparam int NTX = NB + 3;
    localparam int CW  = $clog2(NTX);

    state_t           phase, phase_nxt;
    logic [CW-1:0]    cnt;
    logic [ENC_W-1:0] word_q;
    logic [7:0]       nxt_byte, sum;
    logic             last;
    int               k;

    assign last  = (cnt == CW'(NTX - 1));
    assign tx_dv = (phase == TX_SEND);

    // Byte that follows the current one; the checksum is the default tail byte.
    always_comb begin
        k   = int'(cnt) + 1;
        sum = CMD_GET_ENC;
        for (int i = 0; i < NB; i++) sum = sum ^ word_q[i*8 +: 8];
        nxt_byte = sum;
        if (k == 1)            nxt_byte = CMD_GET_ENC;
        else if (k < NTX - 1)  nxt_byte = word_q[(NB + 1 - k)*8 +: 8];
    end

    always_comb begin
        phase_nxt = phase;
        case (phase)
            IDLE:    if (start) phase_nxt = TX_SEND;
            TX_SEND: phase_nxt = TX_WAIT;
            TX_WAIT: if (tx_done) phase_nxt = last ? IDLE : TX_SEND;
            default: phase_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase   <= IDLE;
            cnt     <= '0;
            word_q  <= '0;
            tx_byte <= 8'h00;
            done    <= 1'b0;
        end else begin
            phase <= phase_nxt;
            done  <= (phase == TX_WAIT) && tx_done && last;
            if (phase == IDLE && start) begin
                word_q  <= word;
                cnt     <= '0;
                tx_byte <= SOM;
            end else if (phase == TX_WAIT && tx_done && !last) begin
                cnt     <= cnt + 1'b1;
                tx_byte <= nxt_byte;
            end
        end
    end

endmodule

// File: rtl/motor_cmd_decoder.sv
// UART command decoder and register bank for NUM_MOTORS motor channels with
// checksummed framing, inter-byte timeout and encoder read-back responses.
module motor_cmd_decoder
    import motor_cmd_pkg::*;
#(
    parameter int NUM_MOTORS   = 2,
    parameter int ENC_W        = 24,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic                        clk_100MHz,
    input  logic                        rst_n,
    input  logic                        i_rx_dv,
    input  logic [7:0]                  i_rx_byte,
    input  logic                        i_tx_done,
    output logic                        o_tx_dv,
    output logic [7:0]                  o_tx_byte,
    input  logic [NUM_MOTORS*ENC_W-1:0] i_enc_cnt,
    output logic [NUM_MOTORS*8-1:0]     o_setpt,
    output logic [7:0]                  o_accel,
    output logic [15:0]                 o_tics_per_rev,
    output logic                        o_zero_encoders,
    output logic                        o_cmd_mode_en,
    output logic [7:0]                  o_err_cnt
);

    localparam int IDX_W = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CLKS);

    state_t                              state, state_nxt;
    logic [7:0]                          cmd_r, chk_acc;
    logic [1:0][7:0]                     pay;
    logic [1:0]                          pay_cnt;
    logic [TMO_W-1:0]                    tmo;
    logic                                err, tmo_hit, idx_bad, in_rx;
    logic                                exec_q, start_q, ser_done;
    logic [NUM_MOTORS-1:0][7:0]          setpt;
    logic [NUM_MOTORS-1:0][ENC_W-1:0]    enc;
    logic [ENC_W-1:0]                    snap;
    logic [IDX_W-1:0]                    idx;

    assign enc     = i_enc_cnt;
    assign o_setpt = setpt;
    assign idx     = pay[0][IDX_W-1:0];
    assign in_rx   = state inside {CMD, PAYLOAD, CHECK};
    assign idx_bad = (cmd_r == CMD_SPEED || cmd_r == CMD_GET_ENC) && (pay[0] >= 8'(NUM_MOTORS));
    assign tmo_hit = in_rx && !i_rx_dv && (tmo == TMO_W'(TIMEOUT_CLKS - 1));
    assign o_zero_encoders = (state == EXEC) && (cmd_r == CMD_RST_ENC);

    always_comb begin
        state_nxt = state;
        err       = 1'b0;
        case (state)
            IDLE:    if (i_rx_dv && i_rx_byte == SOM) state_nxt = CMD;
            CMD: begin
                if (i_rx_dv) begin
                    if (!cmd_known(i_rx_byte)) begin
                        err       = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = (payload_len(i_rx_byte) == 2'd0) ? CHECK : PAYLOAD;
                    end
                end
            end
            PAYLOAD: if (i_rx_dv && pay_cnt == payload_len(cmd_r) - 2'd1) state_nxt = CHECK;
            CHECK: begin
                if (i_rx_dv) begin
                    if (i_rx_byte != chk_acc || idx_bad) begin
                        err       = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = EXEC;
                    end
                end
            end
            EXEC:    state_nxt = (cmd_r == CMD_GET_ENC) ? TX_SEND : IDLE;
            TX_SEND: begin
                if (ser_done)     state_nxt = IDLE;
                else if (o_tx_dv) state_nxt = TX_WAIT;
            end
            TX_WAIT: begin
                if (ser_done)       state_nxt = IDLE;
                else if (i_tx_done) state_nxt = TX_SEND;
            end
            default: state_nxt = IDLE;
        endcase
        if (tmo_hit) begin
            err       = 1'b1;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            state          <= IDLE;
            cmd_r          <= 8'h00;
            chk_acc        <= 8'h00;
            pay            <= '0;
            pay_cnt        <= 2'd0;
            tmo            <= '0;
            exec_q         <= 1'b0;
            start_q        <= 1'b0;
            snap           <= '0;
            setpt          <= '0;
            o_accel        <= 8'h00;
            o_tics_per_rev <= 16'h0000;
            o_cmd_mode_en  <= 1'b0;
            o_err_cnt      <= 8'h00;
        end else begin
            state   <= state_nxt;
            exec_q  <= (state == EXEC);
            start_q <= 1'b0;
            tmo     <= (i_rx_dv || !in_rx) ? '0 : tmo + 1'b1;

            if (i_rx_dv && state == CMD) begin
                cmd_r   <= i_rx_byte;
                chk_acc <= i_rx_byte;
                pay_cnt <= 2'd0;
            end else if (i_rx_dv && state == PAYLOAD) begin
                pay[pay_cnt[0]] <= i_rx_byte;
                chk_acc         <= chk_acc ^ i_rx_byte;
                pay_cnt         <= pay_cnt + 2'd1;
            end

            if (state == EXEC && cmd_r == CMD_GET_ENC) begin
                snap    <= enc[idx];
                start_q <= 1'b1;
            end

            // Register writes land one cycle after EXEC; cmd_r/pay cannot be
            // overwritten before then because bytes in EXEC are dropped.
            if (exec_q) begin
                case (cmd_r)
                    CMD_TICS:  o_tics_per_rev <= {pay[0], pay[1]};
                    CMD_SPEED: begin
                        setpt[idx]    <= pay[1];
                        o_cmd_mode_en <= 1'b1;
                    end
                    CMD_ACCEL: o_accel <= pay[0];
                    default:   ;
                endcase
            end

            if (err && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
        end
    end

    motor_cmd_tx_serializer #(.ENC_W(ENC_W)) u_tx (
        .clk     (clk_100MHz),
        .rst_n   (rst_n),
        .start   (start_q),
        .word    (snap),
        .tx_done (i_tx_done),
        .tx_dv   (o_tx_dv),
        .tx_byte (o_tx_byte),
        .done    (ser_done)
    );

endmodule
